// File: rtl/spi_eeprom_responder_if.sv
// SPI bus between an initiator and the EEPROM responder.
//   sck, cs_n, copi : driven by the initiator (master)
//   cipo, cipo_oe   : driven by the responder (slave); cipo_oe is high while cipo is driven
interface spi_eeprom_responder_if;
   logic sck;
   logic cs_n;
   logic copi;
   logic cipo;
   logic cipo_oe;

   modport master (output sck, output cs_n, output copi, input cipo, input cipo_oe);
   modport slave  (input sck, input cs_n, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 target emulating a small 25xx-style serial EEPROM: command byte,
// 8-bit address, then streamed data. Register-array memory with a host preload port.
// Ports:
//   clk, rst_n         system clock, synchronous active-low reset
//   spi (slave)        sck/cs_n/copi in (async, oversampled), cipo/cipo_oe out
//   load_en/addr/data  host preload write (wins over a same-cycle SPI write)
//   wel                write-enable latch
//   xfer_active        high while a selected transaction is in progress
module spi_eeprom_responder #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned PAGE_SIZE   = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spi_eeprom_responder_if.slave spi,
   input  logic                  load_en,
   input  logic [ADDR_W-1:0]     load_addr,
   input  logic [7:0]            load_data,
   output logic                  wel,
   output logic                  xfer_active
);

   localparam int unsigned PG_W = $clog2(PAGE_SIZE);

   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRDI  = 8'h04;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_WREN  = 8'h06;

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, READ_DATA, WRITE_DATA, STATUS, IGNORE
   } state_t;

   state_t state_q, state_d;

   // One extra flop on sck/cs_n gives the previous synced sample for edge detection.
   // cs_n flops reset low so a select held low through reset shows no falling edge.
   logic [SYNC_STAGES:0]   sck_sr, cs_sr;
   logic [SYNC_STAGES-1:0] copi_sr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_sr  <= '0;
         cs_sr   <= '0;
         copi_sr <= '0;
      end else begin
         sck_sr[0]  <= spi.sck;
         cs_sr[0]   <= spi.cs_n;
         copi_sr[0] <= spi.copi;
         for (int unsigned i = 1; i <= SYNC_STAGES; i++) begin
            sck_sr[i] <= sck_sr[i-1];
            cs_sr[i]  <= cs_sr[i-1];
         end
         for (int unsigned i = 1; i < SYNC_STAGES; i++)
            copi_sr[i] <= copi_sr[i-1];
      end
   end

   logic sck_s, sck_p, cs_s, cs_p, copi_s;
   assign sck_s  = sck_sr[SYNC_STAGES-1];
   assign sck_p  = sck_sr[SYNC_STAGES];
   assign cs_s   = cs_sr[SYNC_STAGES-1];
   assign cs_p   = cs_sr[SYNC_STAGES];
   assign copi_s = copi_sr[SYNC_STAGES-1];

   logic sck_rise, sck_fall, cs_fall;
   assign sck_rise = sck_s & ~sck_p;
   assign sck_fall = ~sck_s & sck_p;
   assign cs_fall  = ~cs_s & cs_p;

   logic [7:0]        mem [2**ADDR_W];
   logic [2:0]        bit_cnt;
   logic [6:0]        shift_in;
   logic [7:0]        shift_out;
   logic [ADDR_W-1:0] addr;
   logic              wel_q, op_read, wrote_any, cipo_q;

   logic [7:0]        rx_byte, status_byte;
   logic [ADDR_W-1:0] addr_inc;
   logic [PG_W-1:0]   pg_next;
   logic              byte_done, tx_active, spi_we;

   assign rx_byte     = {shift_in, copi_s};
   assign status_byte = {6'b0, wel_q, 1'b0};
   assign addr_inc    = addr + ADDR_W'(1);
   assign pg_next     = addr[PG_W-1:0] + PG_W'(1);
   assign byte_done   = sck_rise && (bit_cnt == 3'd0) && !cs_s && (state_q != IDLE);
   assign tx_active   = (state_q == READ_DATA) || (state_q == STATUS);
   assign spi_we      = byte_done && (state_q == WRITE_DATA);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      spi.cipo_oe = 1'b0;
      spi.cipo    = 1'b0;
      xfer_active = 1'b0;
      if (cs_s) begin
         state_d = IDLE;
      end else begin
         xfer_active = (state_q != IDLE);
         spi.cipo_oe = tx_active;
         spi.cipo    = tx_active & cipo_q;
         case (state_q)
            IDLE: if (cs_fall) state_d = CMD;
            CMD: if (byte_done) begin
               case (rx_byte)
                  OP_READ:  state_d = ADDR;
                  OP_WRITE: state_d = wel_q ? ADDR : IGNORE;
                  OP_RDSR:  state_d = STATUS;
                  default:  state_d = IGNORE;
               endcase
            end
            ADDR: if (byte_done) state_d = op_read ? READ_DATA : WRITE_DATA;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt   <= 3'd7;
         shift_in  <= '0;
         shift_out <= '0;
         addr      <= '0;
         wel_q     <= 1'b0;
         op_read   <= 1'b0;
         wrote_any <= 1'b0;
         cipo_q    <= 1'b0;
      end else if (cs_s) begin
         bit_cnt   <= 3'd7;
         cipo_q    <= 1'b0;
         wrote_any <= 1'b0;
         if (wrote_any) wel_q <= 1'b0;
      end else begin
         if (sck_rise && state_q != IDLE) begin
            shift_in <= rx_byte[6:0];
            bit_cnt  <= bit_cnt - 3'd1;
         end
         if (byte_done) begin
            case (state_q)
               CMD: begin
                  op_read <= (rx_byte == OP_READ);
                  if (rx_byte == OP_WREN) wel_q <= 1'b1;
                  if (rx_byte == OP_WRDI) wel_q <= 1'b0;
                  if (rx_byte == OP_RDSR) shift_out <= status_byte;
               end
               ADDR: begin
                  addr <= rx_byte[ADDR_W-1:0];
                  if (op_read) shift_out <= mem[rx_byte[ADDR_W-1:0]];
               end
               WRITE_DATA: begin
                  addr      <= {addr[ADDR_W-1:PG_W], pg_next};
                  wrote_any <= 1'b1;
               end
               default: ;
            endcase
         end
         // The fall that drives bit 0 also fetches the next byte, so the next
         // fall can drive its bit 7 without a gap.
         if (sck_fall && tx_active) begin
            cipo_q <= shift_out[7];
            if (bit_cnt == 3'd0) begin
               if (state_q == STATUS) begin
                  shift_out <= status_byte;
               end else begin
                  shift_out <= mem[addr_inc];
                  addr      <= addr_inc;
               end
            end else begin
               shift_out <= {shift_out[6:0], 1'b0};
            end
         end
      end
   end

   assign wel = wel_q;

   // Preload is written last so it wins a same-cycle, same-address SPI commit.
   always_ff @(posedge clk) begin
      if (spi_we)  mem[addr] <= rx_byte;
      if (load_en) mem[load_addr] <= load_data;
   end

endmodule
